period_timer: RTL and testbench

Parametrised time-of-day counter for the school seating system. It divides `clk` into minute ticks and keeps a minute-of-day count that wraps at a runtime-programmable day length. It raises a day-change reset window for downstream seat/attendance logic and drives N independent alarm channels (period bells). Successor to the fixed 11-bit day timer: adds a prescaler, enable/pause, synchronous load, a day counter and alarm channels.

---
 rtl/period_timer.sv | 143 ++++++++++++++
 tb/tb_period_timer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/period_timer.sv
// ----------------------------------------------------------------------------
// period_timer
//
// Time-of-day counter for the school seating system. A prescaler divides clk
// into minute steps. A minute-of-day counter wraps at a day length that can be
// changed at runtime. The block also keeps a count of completed days, opens a
// day-change reset window for the seat/attendance logic, and drives N
// independent alarm channels (period bells).
//
// Parameters
//   W         width of the minute counter and of all time values
//   TICK_DIV  clk cycles per minute step (>= 1)
//   N_ALARM   number of alarm channels (>= 1)
//   HOLD_MIN  minute at which rst_timer drops after a day change
//   DW        width of the day counter
//
// Ports
//   clk         in   1           system clock, rising edge
//   rst_n       in   1           asynchronous active-low reset
//   en          in   1           count enable; 0 freezes prescaler and minute
//   day_len     in   W           minutes per day, 0 means 2^W
//   load        in   1           synchronous load strobe (wins over a step)
//   load_val    in   W           minute value applied by load
//   alarm_time  in   N_ALARM*W   alarm minutes, channel i at [i*W +: W]
//   alarm_en    in   N_ALARM     per-channel alarm enable
//   time_out    out  W           current minute of day
//   tick        out  1           pulse: time_out advanced this cycle
//   day_wrap    out  1           pulse: time_out wrapped to 0 this cycle
//   rst_timer   out  1           day-change window level
//   day_cnt     out  DW          completed days, modulo 2^DW
//   alarm_hit   out  N_ALARM     per-channel pulse on an alarm match
// ----------------------------------------------------------------------------
module period_timer #(
    parameter int W        = 11,
    parameter int TICK_DIV = 1,
    parameter int N_ALARM  = 4,
    parameter int HOLD_MIN = 360,
    parameter int DW       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [W-1:0]         day_len,
    input  logic                 load,
    input  logic [W-1:0]         load_val,
    input  logic [N_ALARM*W-1:0] alarm_time,
    input  logic [N_ALARM-1:0]   alarm_en,
    output logic [W-1:0]         time_out,
    output logic                 tick,
    output logic                 day_wrap,
    output logic                 rst_timer,
    output logic [DW-1:0]        day_cnt,
    output logic [N_ALARM-1:0]   alarm_hit
);

    // Prescaler is at least one bit wide so TICK_DIV=1 still elaborates;
    // in that case it simply stays at 0 and every enabled edge is a step.
    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    // A HOLD_MIN that cannot be represented in W bits never matches, so the
    // window then stays open until the next load.
    localparam bit           HOLD_IN_RANGE = (HOLD_MIN >= 0) &&
                                             (longint'(HOLD_MIN) < (longint'(1) << W));
    localparam logic [W-1:0] HOLD_VAL      = W'(HOLD_MIN);

    logic [PW-1:0]      r_presc;

    logic [W:0]         w_len;        // effective day length, one bit wider for 2^W
    logic [W:0]         w_last;       // last valid minute of the day
    logic               w_step;
    logic               w_wrap;
    logic [W-1:0]       w_next;
    logic [W-1:0]       w_load_time;
    logic               w_hold_hit;
    logic [N_ALARM-1:0] w_hit;

    assign w_len  = (day_len == '0) ? {1'b1, {W{1'b0}}} : {1'b0, day_len};
    assign w_last = w_len - {{W{1'b0}}, 1'b1};
    assign w_step = en && (r_presc == PRESC_LAST);

    // ">=" rather than "==" so that shortening day_len below the current
    // minute wraps on the very next step instead of running to 2^W.
    assign w_wrap = ({1'b0, time_out} >= w_last);
    assign w_next = w_wrap ? '0 : time_out + W'(1);

    assign w_load_time = ({1'b0, load_val} >= w_len) ? '0 : load_val;
    assign w_hold_hit  = HOLD_IN_RANGE && (w_next == HOLD_VAL);

    // Alarm channels compare against the minute being entered, so a hit lines
    // up with the first cycle that minute is visible on time_out.
    always_comb begin
        // NOTE: default first so no path leaves w_hit unassigned (no latch).
        w_hit = '0;
        for (int i = 0; i < N_ALARM; i++) begin
            w_hit[i] = alarm_en[i] && (alarm_time[i*W +: W] == w_next);
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values and ordering inside the block does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            time_out  <= '0;
            tick      <= 1'b0;
            day_wrap  <= 1'b0;
            rst_timer <= 1'b0;
            day_cnt   <= '0;
            alarm_hit <= '0;
        end else begin
            // Pulses default low; they are raised only on a step edge.
            tick      <= 1'b0;
            day_wrap  <= 1'b0;
            alarm_hit <= '0;

            if (load) begin
                // Load beats a coincident step; day_cnt is left alone.
                time_out  <= w_load_time;
                r_presc   <= '0;
                rst_timer <= 1'b0;
            end else if (en) begin
                if (w_step) begin
                    r_presc   <= '0;
                    time_out  <= w_next;
                    tick      <= 1'b1;
                    day_wrap  <= w_wrap;
                    alarm_hit <= w_hit;
                    if (w_wrap) begin
                        day_cnt   <= day_cnt + DW'(1);
                        // Opening the window wins over HOLD_MIN=0 closing it.
                        rst_timer <= 1'b1;
                    end else if (w_hold_hit) begin
                        rst_timer <= 1'b0;
                    end
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_period_timer.sv
// ----------------------------------------------------------------------------
// tb_period_timer
//
// Directed bench for period_timer. Three instances share the input stimulus:
//   u_a  TICK_DIV=4, HOLD_MIN=360  (prescaler / day wrap / window held open)
//   u_b  TICK_DIV=1, HOLD_MIN=3    (window, alarms, load, day_len change)
//   u_c  TICK_DIV=3                (en gating, asynchronous reset)
// Each scenario resets all instances and then checks one of them. Inputs are
// driven 1 time unit after a rising edge; outputs are sampled at that point.
// ----------------------------------------------------------------------------
module tb_period_timer;

    localparam int W  = 11;
    localparam int NA = 4;
    localparam int DW = 8;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [W-1:0]    day_len;
    logic            load;
    logic [W-1:0]    load_val;
    logic [NA*W-1:0] alarm_time;
    logic [NA-1:0]   alarm_en;

    logic [W-1:0]  a_time, b_time, c_time;
    logic          a_tick, b_tick, c_tick;
    logic          a_wrap, b_wrap, c_wrap;
    logic          a_rstt, b_rstt, c_rstt;
    logic [DW-1:0] a_days, b_days, c_days;
    logic [NA-1:0] a_hit,  b_hit,  c_hit;

    int n_tests;
    int n_fail;

    period_timer #(.W(W), .TICK_DIV(4), .N_ALARM(NA), .HOLD_MIN(360), .DW(DW)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .day_len(day_len), .load(load),
        .load_val(load_val), .alarm_time(alarm_time), .alarm_en(alarm_en),
        .time_out(a_time), .tick(a_tick), .day_wrap(a_wrap), .rst_timer(a_rstt),
        .day_cnt(a_days), .alarm_hit(a_hit)
    );

    period_timer #(.W(W), .TICK_DIV(1), .N_ALARM(NA), .HOLD_MIN(3), .DW(DW)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .day_len(day_len), .load(load),
        .load_val(load_val), .alarm_time(alarm_time), .alarm_en(alarm_en),
        .time_out(b_time), .tick(b_tick), .day_wrap(b_wrap), .rst_timer(b_rstt),
        .day_cnt(b_days), .alarm_hit(b_hit)
    );

    period_timer #(.W(W), .TICK_DIV(3), .N_ALARM(NA), .HOLD_MIN(360), .DW(DW)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .day_len(day_len), .load(load),
        .load_val(load_val), .alarm_time(alarm_time), .alarm_en(alarm_en),
        .time_out(c_time), .tick(c_tick), .day_wrap(c_wrap), .rst_timer(c_rstt),
        .day_cnt(c_days), .alarm_hit(c_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Holds reset across two edges with all inputs quiet, leaving rst_n low.
    task automatic hold_reset();
        rst_n      = 1'b0;
        en         = 1'b0;
        load       = 1'b0;
        load_val   = '0;
        day_len    = W'(10);
        alarm_time = '0;
        alarm_en   = '0;
        cyc();
        cyc();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // ---------------- reset state ----------------
        hold_reset();
        check("rst_time",  a_time, 0);
        check("rst_tick",  a_tick, 0);
        check("rst_wrap",  a_wrap, 0);
        check("rst_rstt",  a_rstt, 0);
        check("rst_days",  a_days, 0);
        check("rst_hit",   a_hit,  0);

        // ---------------- 1: TICK_DIV=4, day_len=10 ----------------
        en    = 1'b1;
        rst_n = 1'b1;
        for (int c = 1; c <= 44; c++) begin
            cyc();
            check("t1_tick", a_tick, (c % 4 == 0) ? 1 : 0);
            check("t1_time", a_time, (c / 4) % 10);
            check("t1_wrap", a_wrap, (c == 40) ? 1 : 0);
            check("t1_days", a_days, (c >= 40) ? 1 : 0);
            // HOLD_MIN=360 >= day_len, so the window stays open after the wrap.
            check("t1_rstt", a_rstt, (c >= 40) ? 1 : 0);
        end

        // ---------------- 2: rst_timer window, HOLD_MIN=3 ----------------
        hold_reset();
        en    = 1'b1;
        rst_n = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            cyc();
            check("t2_time", b_time, c % 10);
            check("t2_tick", b_tick, 1);
            check("t2_rstt", b_rstt, (c >= 10 && c < 13) ? 1 : 0);
        end

        // ---------------- 3: alarms ----------------
        hold_reset();
        alarm_time = {W'(0), W'(5), W'(5), W'(5)};
        alarm_en   = 4'b0011;
        en         = 1'b1;
        rst_n      = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            check("t3_hit", b_hit, (c == 5) ? 3 : 0);
        end
        en = 1'b0;
        for (int c = 6; c <= 8; c++) begin
            cyc();
            check("t3_hold_time", b_time, 5);
            check("t3_hold_hit",  b_hit,  0);
            check("t3_hold_tick", b_tick, 0);
        end
        alarm_en = '0;

        // ---------------- 4: load ----------------
        hold_reset();
        en    = 1'b1;
        rst_n = 1'b1;
        cyc();
        cyc();
        check("t4_pre_time", b_time, 2);
        load     = 1'b1;
        load_val = W'(7);
        cyc();
        check("t4_ld_time", b_time, 7);
        check("t4_ld_tick", b_tick, 0);
        load = 1'b0;
        cyc();
        check("t4_step_time", b_time, 8);
        check("t4_step_tick", b_tick, 1);
        load     = 1'b1;
        load_val = W'(12);
        cyc();
        check("t4_big_time", b_time, 0);
        check("t4_big_tick", b_tick, 0);
        check("t4_big_wrap", b_wrap, 0);
        check("t4_big_days", b_days, 0);

        // ---------------- 5: day_len shortened below time_out ----------------
        load_val = W'(8);
        cyc();
        check("t5_ld8", b_time, 8);
        load    = 1'b0;
        day_len = W'(5);
        cyc();
        check("t5_wrap_time", b_time, 0);
        check("t5_wrap",      b_wrap, 1);
        check("t5_days",      b_days, 1);
        check("t5_rstt",      b_rstt, 1);
        cyc();
        check("t5_next_time", b_time, 1);
        check("t5_next_wrap", b_wrap, 0);
        load     = 1'b1;
        load_val = W'(2);
        cyc();
        check("t5_ld_rstt", b_rstt, 0);
        check("t5_ld_days", b_days, 1);
        check("t5_ld_time", b_time, 2);
        load = 1'b0;

        // ---------------- 6: en gating with TICK_DIV=3, async reset ----------------
        hold_reset();
        rst_n = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            en = (c % 2 == 1);
            cyc();
            check("t6_tick", c_tick, (c == 5 || c == 11) ? 1 : 0);
            check("t6_time", c_time, (c >= 11) ? 2 : (c >= 5) ? 1 : 0);
        end
        // Mid-cycle, away from any edge: outputs must clear without a clock.
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_ar_time", c_time, 0);
        check("t6_ar_tick", c_tick, 0);
        check("t6_ar_wrap", c_wrap, 0);
        check("t6_ar_rstt", c_rstt, 0);
        check("t6_ar_days", c_days, 0);
        check("t6_ar_hit",  c_hit,  0);
        check("t6_ar_btime", b_time, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("t6_exit_tick", c_tick, 0);
        check("t6_exit_time", c_time, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
